// File: rtl/tmr_prescaler.sv
// Timebase for the 8-bit timer clock selector: free-running PCLK prescaler taps
// plus synchronised, edge-selected external count strobes from TMCI0/TMCI1.
module tmr_prescaler #(
  parameter int DIV_WIDTH   = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       EN,
  input  logic       TMCI0,
  input  logic       TMCI1,
  input  logic [1:0] EDGE0,
  input  logic [1:0] EDGE1,
  output logic       P_2,
  output logic       P_8,
  output logic       P_32,
  output logic       P_64,
  output logic       P_1024,
  output logic       P_8192,
  output logic       TMCI0_EDGE,
  output logic       TMCI1_EDGE
);

  // Priming lasts as long as a pin level takes to reach the edge detector.
  localparam int                PRIME_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [DIV_WIDTH-1:0]   cnt;
  logic [1:0]             pin;
  logic [SYNC_STAGES-1:0] sync_p0 [2];
  logic [1:0]             sync_q;
  logic [1:0]             prev_p1;
  logic [1:0]             rise;
  logic [1:0]             fall;
  logic [1:0]             sel_hit;
  logic [PRIME_W-1:0]     prime_cnt;
  logic                   primed;

  // True when the low 'bits' bits of the counter are all ones, i.e. the
  // increment about to happen completes one period of 2^bits.
  function automatic logic tap_full(input logic [DIV_WIDTH-1:0] c, input int bits);
    logic [DIV_WIDTH-1:0] m;
    m = (DIV_WIDTH'(1) << bits) - DIV_WIDTH'(1);
    return (c & m) == m;
  endfunction

  function automatic logic edge_sel(input logic [1:0] sel, input logic r, input logic f);
    return (sel[0] & r) | (sel[1] & f);
  endfunction

  // ---- prescaler: counter and registered tap strobes ----
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt    <= '0;
      P_2    <= 1'b0;
      P_8    <= 1'b0;
      P_32   <= 1'b0;
      P_64   <= 1'b0;
      P_1024 <= 1'b0;
      P_8192 <= 1'b0;
    end else begin
      if (EN) cnt <= cnt + DIV_WIDTH'(1);
      P_2    <= EN & tap_full(cnt, 1);
      P_8    <= EN & tap_full(cnt, 3);
      P_32   <= EN & tap_full(cnt, 5);
      P_64   <= EN & tap_full(cnt, 6);
      P_1024 <= EN & tap_full(cnt, 10);
      P_8192 <= EN & tap_full(cnt, 13);
    end
  end

  // ---- p0: pin synchronisers; p1: previous synced level for edge detect ----
  assign pin = {TMCI1, TMCI0};

  for (genvar i = 0; i < 2; i++) begin : g_pin
    assign sync_q[i] = sync_p0[i][SYNC_STAGES-1];
  end

  assign rise       = sync_q & ~prev_p1;
  assign fall       = ~sync_q & prev_p1;
  assign sel_hit[0] = edge_sel(EDGE0, rise[0], fall[0]);
  assign sel_hit[1] = edge_sel(EDGE1, rise[1], fall[1]);
  assign primed     = (prime_cnt == PRIME_DONE);

  // ---- p2: registered edge strobes, gated until the sync chain holds real pin data ----
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int i = 0; i < 2; i++) sync_p0[i] <= '0;
      prev_p1    <= '0;
      prime_cnt  <= '0;
      TMCI0_EDGE <= 1'b0;
      TMCI1_EDGE <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], pin[i]};
      prev_p1 <= sync_q;
      if (!primed) prime_cnt <= prime_cnt + PRIME_W'(1);
      TMCI0_EDGE <= primed & sel_hit[0];
      TMCI1_EDGE <= primed & sel_hit[1];
    end
  end

endmodule

// File: tb/tb_tmr_prescaler.sv
// Directed self-checking bench for tmr_prescaler: prescaler taps, EN hold,
// external edge selection, priming, mid-run reset and glitch robustness.
module tb_tmr_prescaler;

  logic       clk;
  logic       PRESETn;
  logic       EN;
  logic       TMCI0;
  logic       TMCI1;
  logic [1:0] EDGE0;
  logic [1:0] EDGE1;
  wire        P_2, P_8, P_32, P_64, P_1024, P_8192;
  wire        TMCI0_EDGE, TMCI1_EDGE;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_prescaler dut (
    .PCLK       (clk),
    .PRESETn    (PRESETn),
    .EN         (EN),
    .TMCI0      (TMCI0),
    .TMCI1      (TMCI1),
    .EDGE0      (EDGE0),
    .EDGE1      (EDGE1),
    .P_2        (P_2),
    .P_8        (P_8),
    .P_32       (P_32),
    .P_64       (P_64),
    .P_1024     (P_1024),
    .P_8192     (P_8192),
    .TMCI0_EDGE (TMCI0_EDGE),
    .TMCI1_EDGE (TMCI1_EDGE)
  );

  wire [5:0] pv = {P_8192, P_1024, P_64, P_32, P_8, P_2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; EN = 1'b1; TMCI0 = 1'b0; TMCI1 = 1'b0;
    EDGE0 = 2'b00; EDGE1 = 2'b00;
    tick(); tick();
    n_checks++;
    if (pv !== 6'h00) begin
      n_fail++; $display("FAIL reset_taps: got %b expected 000000", pv);
    end
    n_checks++;
    if ({TMCI1_EDGE, TMCI0_EDGE} !== 2'b00) begin
      n_fail++; $display("FAIL reset_edges: got %b expected 00", {TMCI1_EDGE, TMCI0_EDGE});
    end
  endtask

  task automatic test_count();
    int per [6];
    int mis [6];
    int pulses [6];
    int exp_pulses [6];
    int coin_err;
    per = '{2, 8, 32, 64, 1024, 8192};
    exp_pulses = '{8192, 2048, 512, 256, 16, 2};
    mis = '{0, 0, 0, 0, 0, 0};
    pulses = '{0, 0, 0, 0, 0, 0};
    coin_err = 0;
    PRESETn = 1'b1; EN = 1'b1;
    for (int e = 1; e <= 16384; e++) begin
      tick();
      for (int k = 0; k < 6; k++) begin
        if (pv[k] !== ((e % per[k]) == 0)) mis[k]++;
        if (pv[k] === 1'b1) pulses[k]++;
      end
      if (P_8192 === 1'b1 && pv !== 6'h3f) coin_err++;
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (mis[k] !== 0) begin
        n_fail++; $display("FAIL tap_position_P_%0d: %0d misplaced cycles, expected 0", per[k], mis[k]);
      end
      n_checks++;
      if (pulses[k] !== exp_pulses[k]) begin
        n_fail++; $display("FAIL tap_count_P_%0d: got %0d pulses expected %0d", per[k], pulses[k], exp_pulses[k]);
      end
    end
    n_checks++;
    if (coin_err !== 0) begin
      n_fail++; $display("FAIL p8192_coincide: %0d cycles without all taps, expected 0", coin_err);
    end
  endtask

  // Counter is 0 on entry (16384 edges since release).
  task automatic test_enable_hold();
    int hold_pulses;
    int first;
    logic p2_e1, p2_e2;
    repeat (3000) tick();
    EN = 1'b0;
    hold_pulses = 0;
    repeat (100) begin
      tick();
      if (pv !== 6'h00) hold_pulses++;
    end
    n_checks++;
    if (hold_pulses !== 0) begin
      n_fail++; $display("FAIL en_hold_quiet: got %0d active cycles expected 0", hold_pulses);
    end
    EN = 1'b1;
    first = -1;
    p2_e1 = 1'bx; p2_e2 = 1'bx;
    for (int e = 1; e <= 2000 && first < 0; e++) begin
      tick();
      if (e == 1) p2_e1 = P_2;
      if (e == 2) p2_e2 = P_2;
      if (P_1024 === 1'b1) first = e;
    end
    n_checks++;
    if (first !== 72) begin
      n_fail++; $display("FAIL en_resume_p1024: got edge %0d expected 72", first);
    end
    n_checks++;
    if ({p2_e1, p2_e2} !== 2'b01) begin
      n_fail++; $display("FAIL en_resume_p2_phase: got %b expected 01", {p2_e1, p2_e2});
    end
  endtask

  // Pin rises before edge 1 and falls before edge 13: rise strobe at tick 3,
  // fall strobe at tick 15. The other pin is idle with EDGE=11.
  task automatic test_edge_select(input int pin, input logic [1:0] sel, input logic [23:0] exp_mask);
    logic [23:0] got, other;
    got = '0; other = '0;
    if (pin == 0) begin EDGE0 = sel; EDGE1 = 2'b11; TMCI0 = 1'b1; end
    else          begin EDGE1 = sel; EDGE0 = 2'b11; TMCI1 = 1'b1; end
    for (int t = 1; t < 24; t++) begin
      tick();
      got[t]   = (pin == 0) ? TMCI0_EDGE : TMCI1_EDGE;
      other[t] = (pin == 0) ? TMCI1_EDGE : TMCI0_EDGE;
      if (t == 12) begin
        if (pin == 0) TMCI0 = 1'b0; else TMCI1 = 1'b0;
      end
    end
    n_checks++;
    if (got !== exp_mask) begin
      n_fail++; $display("FAIL edge_sel_pin%0d_sel%b: got %h expected %h", pin, sel, got, exp_mask);
    end
    n_checks++;
    if (other !== 24'h0) begin
      n_fail++; $display("FAIL edge_quiet_pin%0d_sel%b: got %h expected 000000", 1 - pin, sel, other);
    end
  endtask

  task automatic test_prime();
    int n0, n1;
    PRESETn = 1'b0; TMCI0 = 1'b1; TMCI1 = 1'b1; EDGE0 = 2'b11; EDGE1 = 2'b01;
    tick(); tick();
    PRESETn = 1'b1;
    n0 = 0; n1 = 0;
    repeat (40) begin
      tick();
      if (TMCI0_EDGE !== 1'b0) n0++;
      if (TMCI1_EDGE !== 1'b0) n1++;
    end
    n_checks++;
    if (n1 !== 0) begin
      n_fail++; $display("FAIL prime_tmci1: got %0d strobes expected 0", n1);
    end
    n_checks++;
    if (n0 !== 0) begin
      n_fail++; $display("FAIL prime_tmci0: got %0d strobes expected 0", n0);
    end
    EDGE0 = 2'b00; EDGE1 = 2'b00; TMCI0 = 1'b0; TMCI1 = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_mid_reset();
    int early8192, prime_err, post_edges, tog;
    logic p2_e1, p2_e2, p8192_at;
    EN = 1'b1; EDGE0 = 2'b11; EDGE1 = 2'b00; TMCI0 = 1'b0; TMCI1 = 1'b0;
    PRESETn = 1'b0; tick(); PRESETn = 1'b1;
    tog = 0;
    repeat (5000) begin
      tick();
      tog++; if (tog == 3) begin tog = 0; TMCI0 = ~TMCI0; end
    end
    PRESETn = 1'b0;
    tick();
    n_checks++;
    if ({pv, TMCI1_EDGE, TMCI0_EDGE} !== 8'h00) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 00000000", {pv, TMCI1_EDGE, TMCI0_EDGE});
    end
    PRESETn = 1'b1;
    early8192 = 0; prime_err = 0; post_edges = 0;
    p2_e1 = 1'bx; p2_e2 = 1'bx; p8192_at = 1'bx;
    for (int e = 1; e <= 8192; e++) begin
      TMCI0 = ~TMCI0;
      tick();
      if (e == 1) p2_e1 = P_2;
      if (e == 2) p2_e2 = P_2;
      if (e < 8192 && P_8192 !== 1'b0) early8192++;
      if (e == 8192) p8192_at = P_8192;
      if (e <= 3 && TMCI0_EDGE !== 1'b0) prime_err++;
      if (e > 3 && TMCI0_EDGE === 1'b1) post_edges++;
    end
    n_checks++;
    if ({p2_e1, p2_e2} !== 2'b01) begin
      n_fail++; $display("FAIL midreset_p2_first: got %b expected 01", {p2_e1, p2_e2});
    end
    n_checks++;
    if (early8192 !== 0 || p8192_at !== 1'b1) begin
      n_fail++; $display("FAIL midreset_p8192: early %0d at_8192 %b expected early 0 at_8192 1", early8192, p8192_at);
    end
    n_checks++;
    if (prime_err !== 0) begin
      n_fail++; $display("FAIL midreset_priming: got %0d strobes in first 3 edges expected 0", prime_err);
    end
    // Pin toggles before every edge, so once primed every cycle carries a transition.
    n_checks++;
    if (post_edges !== 8189) begin
      n_fail++; $display("FAIL midreset_toggle_edges: got %0d expected 8189", post_edges);
    end
    EDGE0 = 2'b00; TMCI0 = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_glitch(input logic [1:0] sel, input int max_strobes);
    int n, xerr;
    EDGE0 = sel; TMCI0 = 1'b0;
    repeat (6) tick();
    for (int it = 0; it < 16; it++) begin
      n = 0; xerr = 0;
      fork
        begin
          #($urandom_range(0, 8));
          TMCI0 = 1'b1;
          #10;
          TMCI0 = 1'b0;
        end
        begin
          repeat (8) begin
            tick();
            if (TMCI0_EDGE === 1'b1) n++;
            if ($isunknown({pv, TMCI1_EDGE, TMCI0_EDGE})) xerr++;
          end
        end
      join
      n_checks++;
      if (n > max_strobes) begin
        n_fail++; $display("FAIL glitch_sel%b_iter%0d: got %0d strobes expected at most %0d", sel, it, n, max_strobes);
      end
      n_checks++;
      if (xerr !== 0) begin
        n_fail++; $display("FAIL glitch_x_iter%0d: %0d cycles with X expected 0", it, xerr);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_enable_hold();
    test_edge_select(0, 2'b01, 24'h000008);
    test_edge_select(0, 2'b11, 24'h008008);
    test_edge_select(0, 2'b10, 24'h008000);
    test_edge_select(0, 2'b00, 24'h000000);
    test_prime();
    EN = 1'b0;
    test_edge_select(1, 2'b01, 24'h000008);
    test_edge_select(1, 2'b11, 24'h008008);
    EN = 1'b1;
    test_mid_reset();
    test_glitch(2'b11, 2);
    test_glitch(2'b01, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
